// File: rtl/implication_monitor.sv
// Per-channel "a |-> ##DELAY c" (exact) or "a |-> ##[1:DELAY] c" (window) runtime monitor
// with registered fail pulses, sticky error flags and a saturating failure counter.
module implication_monitor #(
  parameter int unsigned N_CH   = 2,
  parameter int unsigned DELAY  = 1,
  parameter int unsigned WINDOW = 0,
  parameter int unsigned CNT_W  = 8
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             en,
  input  logic             clr,
  input  logic [N_CH-1:0]  ant,
  input  logic [N_CH-1:0]  cons,
  output logic [N_CH-1:0]  fail,
  output logic [N_CH-1:0]  err,
  output logic [N_CH-1:0]  pending,
  output logic [CNT_W-1:0] fail_cnt
);

  // Six extra bits hold the largest per-edge popcount (32) without overflow.
  localparam int unsigned SumW = CNT_W + 6;

  logic [DELAY-1:0] obl_q [N_CH];
  logic [DELAY-1:0] obl_d [N_CH];
  logic [N_CH-1:0]  fail_q, fail_d;
  logic [N_CH-1:0]  err_q;
  logic [N_CH-1:0]  pend_q, pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SumW-1:0]  pop;
  logic [SumW-1:0]  sum;

  always_comb begin
    pop = '0;
    for (int i = 0; i < N_CH; i++) begin
      // The oldest stage is due this edge; in window mode cons also clears the whole register,
      // which only ever holds obligations created on earlier edges.
      fail_d[i] = obl_q[i][DELAY-1] & ~cons[i];
      if ((WINDOW != 0) && cons[i]) begin
        obl_d[i] = '0;
      end else begin
        obl_d[i] = obl_q[i] << 1;
      end
      obl_d[i][0] = ant[i] & en;
      pend_d[i]   = |obl_d[i];
      pop         = pop + SumW'(fail_d[i]);
    end
    sum = SumW'(cnt_q) + pop;
    if (sum > SumW'({CNT_W{1'b1}})) begin
      cnt_d = {CNT_W{1'b1}};
    end else begin
      cnt_d = sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETN || clr) begin
      obl_q  <= '{default: '0};
      fail_q <= '0;
      err_q  <= '0;
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      obl_q  <= obl_d;
      fail_q <= fail_d;
      err_q  <= err_q | fail_d;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  assign fail     = fail_q;
  assign err      = err_q;
  assign pending  = pend_q;
  assign fail_cnt = cnt_q;

endmodule
